fp_mantissa_normalizer: RTL
===========================

// Module: fp_mantissa_normalizer
// PURPOSE
//  Consumer side of the leading-zero count: takes an unnormalised mantissa and biased
//  exponent, left-shifts the mantissa until its MSB is 1, and decrements the exponent to match.
//  Sits after the accumulate/add stage of the FP datapath and feeds rounding/packing.
//  Streaming block with valid/ready backpressure and a 2-stage pipeline.
// PARAMETERS
//  MANT_W = 48                  mantissa width in bits (must be >= 7)
//  EXP_W  = 10                  biased exponent width in bits, unsigned
//  CNT_W  = $clog2(MANT_W+1)    leading-zero count width (derived; do not override)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block accepts the beat this cycle
//  in_sign    in   1       sign bit, passed through unchanged
//  in_exp     in   EXP_W   biased exponent
//  in_mant    in   MANT_W  unnormalised mantissa
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts the beat
//  out_sign   out  1       sign bit, delayed to match out_mant
//  out_exp    out  EXP_W   adjusted exponent
//  out_mant   out  MANT_W  normalised mantissa
//  out_zero   out  1       input mantissa was all zero
//  out_uflow  out  1       exponent exhausted before normalisation (subnormal result)
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0; out_sign/exp/mant/zero/uflow = 0. Takes effect immediately,
//    at any point, including mid-stream. In-flight beats are dropped.
//  - adv = !out_valid | out_ready. Both stages advance together on adv. in_ready = adv
//    (combinational from out_ready). A beat is accepted when in_valid & in_ready.
//  - Stage 1 on adv: s1_valid<=in_valid; s1_{sign,exp,mant}<=in_*.
//    Mantissa data may load even when in_valid=0.
//  - LZC register: the counter instance registers every clock with no enable.
//    Its input is lzc_din = adv ? in_mant : s1_mant, so lzc_q == lzc(s1_mant) always,
//    including across multi-cycle stalls.
//  - Stage 2 on adv: out_valid<=s1_valid. With cnt=lzc_q and e=s1_exp:
//      * cnt==MANT_W (zero): out_mant=0, out_exp=0, out_zero=1, out_uflow=0.
//      * cnt<=e (normal): out_mant=s1_mant<<cnt, out_exp=e-cnt. e==cnt gives out_exp=0, uflow=0.
//      * cnt>e (underflow): out_mant=s1_mant<<e, out_exp=0, out_uflow=1.
//  - The subtraction is done at max(EXP_W,CNT_W)+1 bits; the compare is unsigned.
//    The shift amount is never > MANT_W-1 for a nonzero mantissa.
//  - Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 beat/cycle.
//  - Stall: while out_valid & !out_ready, all stage registers hold and in_ready=0.
//    The output holds stable until accepted (valid must not drop, data must not change).
//  - Simultaneous out-accept and in-accept in the same cycle is a normal advance: no bubble, no loss.
//  - Order is preserved. No beat is ever duplicated or dropped, except by reset.
// STRUCTURE
//  - Shared package fp_norm_pkg holds the typedef of the {zero,uflow} flag struct.
//    The rounding/pack stage consumes the same type.
//  - One sub-module: a10_leading_zero_counter with SIZE=MANT_W
//    (1-cycle registered count, no reset needed: its value is qualified by s1_valid).
//  - The barrel shifter and exponent adjust are inline in stage 2. No FSM beyond the valid bits.
// TESTING (MANT_W=48, EXP_W=10, out_ready=1 unless stated)
//  1 mant=48'h8000_0000_0000, exp=100
//      -> 2 cycles later: mant unchanged, exp=100, zero=0, uflow=0.
//  2 mant=48'h0000_0000_0001, exp=200
//      -> mant=48'h8000_0000_0000, exp=153, flags 0.
//  3 mant=48'h0000_0001_0000 (cnt=31), exp=10
//      -> mant=48'h0000_0400_0000, exp=0, uflow=1.
//  4 mant=0, exp=77, sign=1
//      -> mant=0, exp=0, zero=1, uflow=0, out_sign=1.
//  5 Stream of 8 random beats, out_ready pattern 1,0,0,1,0,1,1,0,...
//      -> outputs match the golden model in order.
//      -> in_ready==(!out_valid|out_ready) every cycle.
//      -> Output stays stable while stalled.
//  6 rst pulsed while 2 beats are in flight
//      -> out_valid=0 in the same cycle, no stale beat after release.
//      -> Next accepted beat is correct.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types for the FP normalise/round/pack datapath.
// The flag struct travels from the normaliser into the rounding/pack stage.
package fp_norm_pkg;

    typedef struct packed {
        logic zero;   // input mantissa was all zero
        logic uflow;  // exponent ran out before the MSB reached the top
    } norm_flags_t;

    localparam norm_flags_t NORM_FLAGS_NONE = '{zero: 1'b0, uflow: 1'b0};

endpackage

// File: rtl/a10_leading_zero_counter.sv
// Registered leading-zero counter: count_q = number of zeros above the highest set bit of din,
// or SIZE when din is all zero. One cycle of latency, no reset (consumer qualifies it).
module a10_leading_zero_counter #(
    parameter int SIZE = 48,
    parameter int CW   = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic [SIZE-1:0] din,
    output logic [CW-1:0]   count_q
);

    logic [CW-1:0] count_d;

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        count_d = CW'(SIZE);
        for (int i = 0; i < SIZE; i++) begin
            if (din[i]) begin
                count_d = CW'(SIZE - 1 - i);
            end
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/fp_mantissa_normalizer.sv
// Two-stage streaming mantissa normaliser: shifts the mantissa left until its MSB is set and
// lowers the biased exponent to match, flagging zero and subnormal (exponent-exhausted) results.
module fp_mantissa_normalizer
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_uflow
);

    localparam int CNT_W = $clog2(MANT_W + 1);
    localparam int DW    = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ALL_ZERO = CNT_W'(MANT_W);

    logic              adv;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
    logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;

    logic              out_valid_q, out_valid_d;
    logic              out_sign_q,  out_sign_d;
    logic [EXP_W-1:0]  out_exp_q,   out_exp_d;
    logic [MANT_W-1:0] out_mant_q,  out_mant_d;
    norm_flags_t       flags_q,     flags_d;

    logic [MANT_W-1:0] lzc_din;
    logic [CNT_W-1:0]  lzc_q;

    logic [DW-1:0]     exp_ext, cnt_ext, exp_diff;
    logic              cnt_fits;
    logic [CNT_W-1:0]  shamt;
    logic              diff_unused;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // While stalled the counter re-counts the held stage-1 mantissa, so lzc_q always tracks s1_mant_q.
    assign lzc_din = adv ? in_mant : s1_mant_q;

    a10_leading_zero_counter #(
        .SIZE (MANT_W),
        .CW   (CNT_W)
    ) u_lzc (
        .clk     (clk),
        .din     (lzc_din),
        .count_q (lzc_q)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_sign;
            s1_exp_d   = in_exp;
            s1_mant_d  = in_mant;
        end
    end

    // Widened so neither operand wraps; underflow limits the shift to the exponent itself,
    // which is then below the count and therefore fits in CNT_W bits.
    assign exp_ext     = DW'(s1_exp_q);
    assign cnt_ext     = DW'(lzc_q);
    assign exp_diff    = exp_ext - cnt_ext;
    assign cnt_fits    = (cnt_ext <= exp_ext);
    assign shamt       = cnt_fits ? lzc_q : exp_ext[CNT_W-1:0];
    assign diff_unused = ^exp_diff[DW-1:EXP_W];

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        flags_d     = flags_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            out_sign_d  = s1_sign_q;
            if (lzc_q == CNT_ALL_ZERO) begin
                out_mant_d    = '0;
                out_exp_d     = '0;
                flags_d       = NORM_FLAGS_NONE;
                flags_d.zero  = 1'b1;
            end else if (cnt_fits) begin
                out_mant_d = s1_mant_q << shamt;
                out_exp_d  = exp_diff[EXP_W-1:0];
                flags_d    = NORM_FLAGS_NONE;
            end else begin
                out_mant_d    = s1_mant_q << shamt;
                out_exp_d     = '0;
                flags_d       = NORM_FLAGS_NONE;
                flags_d.uflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            flags_q     <= NORM_FLAGS_NONE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = flags_q.zero;
    assign out_uflow = flags_q.uflow;

endmodule
